// File: rtl/bus_pkg.sv
// bus_pkg: shared bus transfer types, arbiter state encoding and error read data.
package bus_pkg;
    typedef enum logic {READ = 1'b0, WRITE = 1'b1} ttype_e;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} tsize_e;
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_e;
    localparam logic [31:0] BUS_ERR_RDATA = 32'hDEADBEEF;
endpackage

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr: counts granted cycles without completion; expired marks the TIMEOUT-th such cycle.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end
    // cnt holds the stalled cycles already elapsed, so this cycle is number cnt+1
    assign expired = en && (cnt >= W'(TIMEOUT - 1));
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two masters sharing one slave, fixed m1 priority with transfer timeout.
// Define BUS_ARB_ROUND_ROBIN_EN to alternate the winner when both masters request.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_breq,
    input  logic        m0_bstart,
    input  logic        m0_ttype,
    input  logic [1:0]  m0_tsize,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_bdone,
    output logic        m0_berr,
    input  logic        m1_breq,
    input  logic        m1_bstart,
    input  logic        m1_ttype,
    input  logic [1:0]  m1_tsize,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_bdone,
    output logic        m1_berr,
    output logic        s_breq,
    output logic        s_bstart,
    output logic        s_ttype,
    output logic [1:0]  s_tsize,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_bdone
);
    arb_state_e state;
    logic g0, g1, busy, expired, pick1;
    assign g0 = (state == GNT0);
    assign g1 = (state == GNT1);
    assign busy = g0 || g1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic last_grant;
    assign pick1 = m1_breq && (!m0_breq || !last_grant);
`else
    assign pick1 = m1_breq;
`endif
    bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk(clk),
        .rst_n(rst_n),
        .clear(!busy),
        .en(busy && !s_bdone),
        .expired(expired)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
        end else if (state == IDLE) begin
            state <= pick1 ? GNT1 : (m0_breq ? GNT0 : IDLE);
`ifdef BUS_ARB_ROUND_ROBIN_EN
            if (pick1 || m0_breq)
                last_grant <= pick1;
`endif
        end else if (s_bdone || expired) begin
            state <= IDLE;
        end
    end
    // expired is never set alongside s_bdone, so a coincident completion stays clean
    assign s_breq   = g0 ? m0_breq : (g1 && m1_breq);
    assign s_bstart = !expired && (g0 ? m0_bstart : (g1 && m1_bstart));
    assign s_ttype  = g0 ? m0_ttype : (g1 && m1_ttype);
    assign s_tsize  = g0 ? m0_tsize : (g1 ? m1_tsize : 2'd0);
    assign s_addr   = g0 ? m0_addr : (g1 ? m1_addr : 32'd0);
    assign s_wdata  = g0 ? m0_wdata : (g1 ? m1_wdata : 32'd0);
    assign m0_bdone = g0 && (s_bdone || expired);
    assign m0_berr  = g0 && expired;
    assign m0_rdata = !g0 ? 32'd0 : (expired ? BUS_ERR_RDATA : s_rdata);
    assign m1_bdone = g1 && (s_bdone || expired);
    assign m1_berr  = g1 && expired;
    assign m1_rdata = !g1 ? 32'd0 : (expired ? BUS_ERR_RDATA : s_rdata);
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: randomized masters and slave with a transfer-level scoreboard for bus_arbiter.
module tb_bus_arbiter;
    import bus_pkg::*;
    localparam int TO = 4;
    typedef struct {
        logic        err;
        logic [31:0] rd;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] breq, bstart, ttype, bdone, berr;
    logic [1:0][1:0] tsize;
    logic [1:0][31:0] addr, wdata, rdata;
    logic s_breq, s_bstart, s_ttype, s_bdone;
    logic [1:0] s_tsize;
    logic [31:0] s_addr, s_wdata, s_rdata;
    int tr_lat[2];
    logic [31:0] tr_rd[2];
    exp_t exp_q[2][$];
    int checks = 0, errors = 0, gcnt = 0, cur_m = -1;
    bit was_idle = 1'b1, after_done = 1'b0, mon_en = 1'b0, last_g = 1'b0;
    logic [1:0] req_snap = 2'b00;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_breq(breq[0]), .m0_bstart(bstart[0]), .m0_ttype(ttype[0]), .m0_tsize(tsize[0]),
        .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_rdata(rdata[0]), .m0_bdone(bdone[0]), .m0_berr(berr[0]),
        .m1_breq(breq[1]), .m1_bstart(bstart[1]), .m1_ttype(ttype[1]), .m1_tsize(tsize[1]),
        .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_rdata(rdata[1]), .m1_bdone(bdone[1]), .m1_berr(berr[1]),
        .s_breq(s_breq), .s_bstart(s_bstart), .s_ttype(s_ttype), .s_tsize(s_tsize),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_bdone(s_bdone)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Arbitration rule: an idle bus hands the grant to m1 when it asks, else to m0.
    function automatic int pick(logic [1:0] r);
`ifdef BUS_ARB_ROUND_ROBIN_EN
        if (&r) return last_g ? 0 : 1;
`endif
        return r[1] ? 1 : (r[0] ? 0 : -1);
    endfunction

    function automatic int kexp(int lat);
        return (lat > TO) ? TO : lat;
    endfunction

    task automatic issue(int m, logic tt, logic [1:0] ts, logic [31:0] a, logic [31:0] w,
                         int lat, logic [31:0] rd);
        exp_t e;
        @(negedge clk);
        #1;
        ttype[m] = tt; tsize[m] = ts; addr[m] = a; wdata[m] = w;
        tr_lat[m] = lat; tr_rd[m] = rd;
        e.err = (lat > TO);
        e.rd = (lat > TO) ? 32'hDEADBEEF : rd;
        exp_q[m].push_back(e);
        breq[m] = 1'b1; bstart[m] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bdone[m]) break;
        end
        chk($sformatf("wait_done%0d", m), {31'd0, bdone[m]}, 32'd1);
        #1;
        breq[m] = 1'b0; bstart[m] = 1'b0;
    endtask

    task automatic rand_master(int m, int n);
        logic [31:0] a;
        repeat (n) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a = $urandom;
            a[0] = m[0];
            issue(m, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), a, $urandom,
                  $urandom_range(1, TO + 2), $urandom);
        end
    endtask

    always @(posedge clk) req_snap <= breq;

    // Slave: identifies the routed transfer by address and completes it after its planned latency.
    initial begin
        s_bdone = 1'b0;
        s_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (s_breq) begin
                cur_m = (breq[1] && s_addr == addr[1]) ? 1 : ((breq[0] && s_addr == addr[0]) ? 0 : -1);
                gcnt++;
                s_bdone = (cur_m >= 0) ? (gcnt == tr_lat[cur_m]) : 1'b0;
                s_rdata = s_bdone ? tr_rd[cur_m] : $urandom;
            end else begin
                cur_m = -1;
                gcnt = 0;
                s_bdone = 1'b0;
                s_rdata = $urandom;
            end
        end
    end

    always @(negedge clk) begin : monitor
        int g, o;
        exp_t e;
        if (mon_en && rst_n) begin
            if (was_idle) begin
                g = pick(req_snap);
                if (g < 0) chk("idle_hold", {31'd0, s_breq}, 32'd0);
                else begin
                    chk("grant_addr", s_addr, addr[g]);
`ifdef BUS_ARB_ROUND_ROBIN_EN
                    last_g = g[0];
`endif
                end
            end
            if (after_done) chk("gap", {30'd0, s_breq, s_bstart}, 32'd0);
            if (!s_breq) begin
                chk("idle_rdata0", rdata[0], 32'd0);
                chk("idle_rdata1", rdata[1], 32'd0);
                chk("idle_flags", {28'd0, bdone, berr}, 32'd0);
            end else if (cur_m < 0) begin
                chk("route", s_addr, addr[0]);
            end else begin
                o = 1 - cur_m;
                chk("fwd_wdata", s_wdata, wdata[cur_m]);
                chk("fwd_type", {29'd0, s_ttype, s_tsize}, {29'd0, ttype[cur_m], tsize[cur_m]});
                chk("fwd_bstart", {31'd0, s_bstart}, {31'd0, !(gcnt == TO && tr_lat[cur_m] > TO)});
                chk("other_flags", {30'd0, bdone[o], berr[o]}, 32'd0);
                chk("other_rdata", rdata[o], 32'd0);
                chk("bdone", {31'd0, bdone[cur_m]}, {31'd0, gcnt == kexp(tr_lat[cur_m])});
                if (bdone[cur_m] && exp_q[cur_m].size() > 0) begin
                    e = exp_q[cur_m].pop_front();
                    chk("berr", {31'd0, berr[cur_m]}, {31'd0, e.err});
                    chk("rdata", rdata[cur_m], e.rd);
                end
            end
            was_idle = !s_breq;
            after_done = |bdone;
        end
    end

    initial begin
        rst_n = 1'b0;
        breq = '0; bstart = '0; ttype = '0; tsize = '0; addr = '0; wdata = '0;
        tr_lat[0] = 0; tr_lat[1] = 0; tr_rd[0] = '0; tr_rd[1] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sctl", {28'd0, s_breq, s_bstart, s_ttype, s_tsize}, 32'd0);
        chk("rst_saddr", s_addr, 32'd0);
        chk("rst_swdata", s_wdata, 32'd0);
        chk("rst_rdata0", rdata[0], 32'd0);
        chk("rst_rdata1", rdata[1], 32'd0);
        chk("rst_flags", {28'd0, bdone, berr}, 32'd0);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        issue(0, READ, WORD, 32'h0000_0100, 32'h0, 3, 32'h1234_5678);
        fork
            issue(1, WRITE, WORD, 32'h2000_0000, 32'hCAFE_BABE, 2, 32'h0);
            issue(0, READ, HALF, 32'h0000_0104, 32'h0, 1, 32'h5555_AAAA);
        join
        issue(1, READ, WORD, 32'h0000_0200, 32'h0, 100, 32'h0BAD_0BAD);
        issue(0, READ, BYTE, 32'h0000_0300, 32'h0, TO, 32'hA5A5_0001);
        fork
            rand_master(0, 15);
            rand_master(1, 15);
        join
        @(negedge clk);
        #1;
        addr[0] = 32'h0000_0400; wdata[0] = 32'h1111_2222; tr_lat[0] = 100;
        breq[0] = 1'b1; bstart[0] = 1'b1;
        @(negedge clk);
        chk("rst_test_granted", {31'd0, s_breq}, 32'd1);
        #1;
        mon_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_bdone", {31'd0, bdone[0]}, 32'd0);
        chk("rst_mid_bstart", {31'd0, s_bstart}, 32'd0);
        chk("rst_mid_idle", s_addr, 32'd0);
        #1;
        breq[0] = 1'b0; bstart[0] = 1'b0;
        @(negedge clk);
        chk("rst_hold_bdone", {31'd0, bdone[0]}, 32'd0);
        rst_n = 1'b1;
        chk("leftover0", exp_q[0].size(), 32'd0);
        chk("leftover1", exp_q[1].size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of cycles a granted transfer may wait for s_bdone before the arbiter aborts it.
REQ-002 Ports (m0 = instruction master, m1 = data master, s = shared slave):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mX_breq  in  1  master X requests the bus (X = 0, 1).
- mX_bstart  in  1  master X starts its transfer.
- mX_ttype  in  1  READ = 0, WRITE = 1.
- mX_tsize  in  2  BYTE = 0, HALF = 1, WORD = 2.
- mX_addr  in  32  transfer address.
- mX_wdata  in  32  write data.
- mX_rdata  out  32  read data returned to master X.
- mX_bdone  out  1  transfer complete for master X.
- mX_berr  out  1  master X's transfer was aborted by timeout; valid with mX_bdone.
- s_breq, s_bstart, s_ttype, s_tsize, s_addr, s_wdata  out  1/1/1/2/32/32  forwarded from the granted master.
- s_rdata  in  32  read data from the slave.
- s_bdone  in  1  slave has completed the transfer.

Function
REQ-003 The arbiter shall be a three-state FSM with states IDLE, GNT0 and GNT1, held in a single registered state variable.
REQ-004 Transitions out of IDLE:
- goes to GNT1 if m1_breq is high;
- otherwise goes to GNT0 if m0_breq is high;
- otherwise stays in IDLE.
- When round-robin arbitration is compiled in (REQ-014), REQ-014 overrides this order.
REQ-005 Grant latency: a request sampled in IDLE at edge N shall give a granted state from edge N onward; routing to the slave shall be valid in cycle N+1.
REQ-006 In GNTx, all s_* outputs shall equal the corresponding mX_* inputs combinationally.
REQ-007 In IDLE, all s_* outputs shall be 0.
REQ-008 In GNTx:
- mX_bdone shall equal s_bdone and mX_rdata shall equal s_rdata;
- the non-granted master shall see bdone = 0, rdata = 0 and berr = 0.
REQ-009 Grant release: GNTx shall return to IDLE on the edge where s_bdone = 1 or a timeout fires. There shall be no back-to-back grant without an intervening IDLE cycle.
REQ-010 A granted master that deasserts mX_breq before s_bdone shall not cause release; the grant shall hold until completion or timeout.
REQ-011 Timeout counter:
- 8-bit or larger; clears on entry to GNTx and increments each GNTx cycle in which s_bdone = 0.
- When it reaches TIMEOUT, the arbiter shall, in that cycle, drive mX_bdone = 1, mX_berr = 1 and mX_rdata = 32'hDEADBEEF, and force s_bstart = 0.
- It shall then go to IDLE.
REQ-012 If s_bdone = 1 in the same cycle the counter reaches TIMEOUT, the arbiter shall treat it as a normal completion (berr = 0, rdata = s_rdata).
REQ-013 If both masters request in the same IDLE cycle, exactly one shall be granted. The losing request shall remain pending and be granted after the next IDLE cycle.

Configuration
REQ-014 Macro BUS_ARB_ROUND_ROBIN_EN:
- When defined, IDLE shall grant the master that was not granted last whenever both request. A 1-bit last-grant register resets to 0, so m1 wins the first tie.
- When undefined, REQ-004 fixed priority (m1 over m0) applies and the last-grant register shall not exist.

Reset
REQ-015 When rst_n = 0 at a clock edge:
- state shall become IDLE and the timeout counter 0;
- the last-grant register (if present) shall become 0;
- all outputs shall be 0 in the following cycle.
REQ-016 Reset asserted mid-transfer shall abandon the transfer without asserting any mX_bdone. The slave shall see s_bstart = 0 from the cycle after the reset edge.

Structure
REQ-017 Package bus_pkg shall hold:
- ttype_e and tsize_e;
- arb_state_e (IDLE, GNT0, GNT1);
- the constant BUS_ERR_RDATA = 32'hDEADBEEF.
REQ-018 The timeout counter shall be a sub-module bus_timeout_ctr with ports clk, rst_n, clear, en, expired and a TIMEOUT parameter.

Verification
REQ-019 Single m0 READ WORD, addr 0x0000_0100, slave replies s_bdone after 3 cycles with 0x1234_5678 -> m0_rdata = 0x1234_5678 with m0_bdone for one cycle, m0_berr = 0, state back to IDLE next edge.
REQ-020 m0 and m1 request in the same IDLE cycle, fixed priority -> m1's WRITE (addr 0x2000_0000, wdata 0xCAFEBABE) appears on the slave first; m0 is granted only after one IDLE cycle.
REQ-021 Slave never asserts s_bdone, TIMEOUT = 4 -> m1_bdone = m1_berr = 1 and m1_rdata = 0xDEADBEEF on the 4th granted cycle, then IDLE.
REQ-022 s_bdone coincides with timeout expiry -> berr = 0 and rdata = s_rdata.
REQ-023 With BUS_ARB_ROUND_ROBIN_EN, both masters requesting continuously for 6 transfers -> grants alternate m1, m0, m1, m0, m1, m0.
REQ-024 rst_n pulled low during GNT0 with the slave mid-transfer -> no m0_bdone, s_bstart = 0 the next cycle, state IDLE.
